register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 38 +++
 rtl/register_file.sv | 81 ++++++++
 2 files changed

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Read/write port bundle for the 16-entry register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int DATA_WIDTH = 16
);
    logic [3:0]            SrcReg1;
    logic [3:0]            SrcReg2;
    logic [3:0]            DstReg;
    logic                  WriteReg;
    logic [DATA_WIDTH-1:0] DstData;
    logic [DATA_WIDTH-1:0] SrcData1;
    logic [DATA_WIDTH-1:0] SrcData2;

    modport master (
        output SrcReg1,
        output SrcReg2,
        output DstReg,
        output WriteReg,
        output DstData,
        input  SrcData1,
        input  SrcData2
    );

    modport slave (
        input  SrcReg1,
        input  SrcReg2,
        input  DstReg,
        input  WriteReg,
        input  DstData,
        output SrcData1,
        output SrcData2
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 16 x DATA_WIDTH register file, two combinational read ports
//               with write-to-read bypass, one write port, optional zero reg.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter bit ZERO_REG   = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    register_file_if.slave rf
);

    localparam int c_NUM_REGS = 16;

    logic [c_NUM_REGS-1:0] w_wl_wr;
    logic [c_NUM_REGS-1:0] w_wl_rd1;
    logic [c_NUM_REGS-1:0] w_wl_rd2;
    logic [DATA_WIDTH-1:0] w_q [c_NUM_REGS];
    logic                  w_wr_valid;
    logic                  w_byp1;
    logic                  w_byp2;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // One-hot wordline decoders, one per port
    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_decode
        assign w_wl_wr[gi]  = (rf.DstReg  == 4'(gi));
        assign w_wl_rd1[gi] = (rf.SrcReg1 == 4'(gi));
        assign w_wl_rd2[gi] = (rf.SrcReg2 == 4'(gi));
    end

    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_regs
        if ((gi == 0) && ZERO_REG) begin : g_zero
            // Hardwired zero: no storage, so writes have nowhere to land
            assign w_q[gi] = '0;
        end else begin : g_store
            logic                  w_we;
            logic [DATA_WIDTH-1:0] r_q;

            assign w_we = rf.WriteReg & w_wl_wr[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_we) begin
                    r_q <= rf.DstData;
                end
            end

            assign w_q[gi] = r_q;
        end
    end

    // AND-OR read mux driven by the one-hot wordlines
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            if (w_wl_rd1[i]) begin
                w_rd1 = w_rd1 | w_q[i];
            end
            if (w_wl_rd2[i]) begin
                w_rd2 = w_rd2 | w_q[i];
            end
        end
    end

    // A write aimed at the hardwired zero register must not bypass either
    assign w_wr_valid = rf.WriteReg & ~(ZERO_REG & w_wl_wr[0]);
    assign w_byp1     = w_wr_valid & (|(w_wl_wr & w_wl_rd1));
    assign w_byp2     = w_wr_valid & (|(w_wl_wr & w_wl_rd2));

    assign rf.SrcData1 = w_byp1 ? rf.DstData : w_rd1;
    assign rf.SrcData2 = w_byp2 ? rf.DstData : w_rd2;

endmodule
`default_nettype wire
